// File: rtl/imem_responder_if.sv
// Fetch-side request/acknowledge port of the instruction-memory responder.
// The fetch stage is the master; the responder is the slave.
interface imem_responder_if;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        fe_err;

  modport master (
    output fe_req, fe_addr,
    input  fe_ack, fe_data, fe_err
  );

  modport slave (
    input  fe_req, fe_addr,
    output fe_ack, fe_data, fe_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed RAM at BASE_ADDR answering fetch requests
// after a fixed latency, with redirect abort, a loader write port and an ack counter.
module imem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  imem_responder_if.slave        fe,
  input  logic                   ld_wen_i,
  input  logic [31:0]            ld_addr_i,
  input  logic [31:0]            ld_data_i,
  output logic [31:0]            ack_count_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && ((off >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stage_data_q, stage_data_d;
  logic        stage_err_q, stage_err_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] ack_count_q, ack_count_d;
  logic        ack;
  logic        start;
  logic        rd_en;

  assign ack = (state_q == StAck) && fe.fe_req && (fe.fe_addr == lat_addr_q);

  always_comb begin
    state_d      = state_q;
    lat_addr_d   = lat_addr_q;
    cnt_d        = cnt_q;
    stage_data_d = stage_data_q;
    stage_err_d  = stage_err_q;
    hold_data_d  = hold_data_q;
    ack_count_d  = ack_count_q;
    start        = 1'b0;
    rd_en        = 1'b0;

    case (state_q)
      StIdle: start = fe.fe_req;
      StWait: begin
        if (!fe.fe_req) begin
          state_d = StIdle;
        end else if (fe.fe_addr != lat_addr_q) begin
          start = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StAck;
            rd_en   = 1'b1;
          end
        end
      end
      StAck: begin
        if (ack) begin
          state_d     = StIdle;
          hold_data_d = stage_data_q;
          ack_count_d = ack_count_q + 32'd1;
        end else if (fe.fe_req) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new or redirected request latches its address; with LATENCY 1 it reads immediately.
    if (start) begin
      lat_addr_d = fe.fe_addr;
      cnt_d      = CntInit;
      if (LATENCY == 1) begin
        state_d = StAck;
        rd_en   = 1'b1;
      end else begin
        state_d = StWait;
      end
    end

    if (rd_en) begin
      stage_err_d  = !addr_ok(lat_addr_d);
      stage_data_d = addr_ok(lat_addr_d) ? mem_q[addr_idx(lat_addr_d)] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      lat_addr_q   <= 32'h0;
      cnt_q        <= 4'd0;
      stage_data_q <= Nop;
      stage_err_q  <= 1'b0;
      hold_data_q  <= Nop;
      ack_count_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      cnt_q        <= cnt_d;
      stage_data_q <= stage_data_d;
      stage_err_q  <= stage_err_d;
      hold_data_q  <= hold_data_d;
      ack_count_q  <= ack_count_d;
    end
  end

  // RAM is not reset; the stage read above sees contents before this edge's write.
  always_ff @(posedge clk) begin
    if (ld_wen_i && addr_ok(ld_addr_i)) begin
      mem_q[addr_idx(ld_addr_i)] <= ld_data_i;
    end
  end

  assign fe.fe_ack  = ack;
  assign fe.fe_data = (state_q == StAck) ? stage_data_q : hold_data_q;
  assign fe.fe_err  = ack && stage_err_q;
  assign ack_count_o = ack_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances at LATENCY 1, 3 and 4 sharing clock,
// reset and loader port; each step drives inputs at the falling edge and checks 1 ns later.
module tb_imem_responder;

  localparam logic [31:0] Base = 32'h8000_0000;
  localparam logic [31:0] W0   = 32'h0010_0093;
  localparam logic [31:0] W1   = 32'h0020_0113;
  localparam logic [31:0] WA   = 32'hAAAA_0001;
  localparam logic [31:0] W4   = 32'h0040_0213;
  localparam logic [31:0] WB   = 32'hBBBB_0002;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_wen;
  logic [31:0] ld_addr, ld_data;
  logic [31:0] cnt1, cnt3, cnt4;

  int checks = 0;
  int errors = 0;

  imem_responder_if fe1();
  imem_responder_if fe3();
  imem_responder_if fe4();

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(4096), .LATENCY(1), .BASE_ADDR(Base)) u_l1 (
    .clk(clk), .reset_n(reset_n), .fe(fe1),
    .ld_wen_i(ld_wen), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ack_count_o(cnt1)
  );
  imem_responder #(.DEPTH(4096), .LATENCY(3), .BASE_ADDR(Base)) u_l3 (
    .clk(clk), .reset_n(reset_n), .fe(fe3),
    .ld_wen_i(ld_wen), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ack_count_o(cnt3)
  );
  imem_responder #(.DEPTH(4096), .LATENCY(4), .BASE_ADDR(Base)) u_l4 (
    .clk(clk), .reset_n(reset_n), .fe(fe4),
    .ld_wen_i(ld_wen), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ack_count_o(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ld_wen = 1'b0; ld_addr = '0; ld_data = '0;
    fe1.fe_req = 1'b0; fe1.fe_addr = Base;
    fe3.fe_req = 1'b0; fe3.fe_addr = Base;
    fe4.fe_req = 1'b0; fe4.fe_addr = Base;
    repeat (3) nxt();
    settle();
    chk("rst_ack", {31'b0, fe1.fe_ack}, 32'd0);
    chk("rst_err", {31'b0, fe1.fe_err}, 32'd0);
    chk("rst_data", fe1.fe_data, Nop);
    chk("rst_data_l3", fe3.fe_data, Nop);
    chk("rst_count", cnt1, 32'd0);

    // Load RAM[0], RAM[1], RAM[2], RAM[4] through the shared loader port.
    nxt(); reset_n = 1'b1;
    ld_wen = 1'b1; ld_addr = Base;         ld_data = W0;
    nxt(); ld_addr = Base + 32'd4;  ld_data = W1;
    nxt(); ld_addr = Base + 32'd8;  ld_data = WA;
    nxt(); ld_addr = Base + 32'd16; ld_data = W4;
    nxt(); ld_addr = Base + 32'h4000; ld_data = 32'hDEAD_BEEF; // out of range, dropped
    nxt(); ld_wen = 1'b0;

    // LATENCY 1 single fetch.
    nxt(); fe1.fe_req = 1'b1; fe1.fe_addr = Base; settle();
    chk("l1_c0_ack", {31'b0, fe1.fe_ack}, 32'd0);
    nxt(); settle();
    chk("l1_c1_ack", {31'b0, fe1.fe_ack}, 32'd1);
    chk("l1_c1_data", fe1.fe_data, W0);
    chk("l1_c1_err", {31'b0, fe1.fe_err}, 32'd0);
    nxt(); fe1.fe_req = 1'b0; settle();
    chk("l1_c2_ack", {31'b0, fe1.fe_ack}, 32'd0);
    chk("l1_c2_data", fe1.fe_data, W0);
    chk("l1_c2_count", cnt1, 32'd1);

    // LATENCY 3 sequential fetches; address advances in the cycle after each ack.
    for (int i = 0; i < 12; i++) begin
      nxt();
      fe3.fe_req = 1'b1;
      fe3.fe_addr = Base + 32'(4 * (i / 4));
      settle();
      chk($sformatf("seq_c%0d_ack", i), {31'b0, fe3.fe_ack}, (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i == 3)  chk("seq_c3_data", fe3.fe_data, W0);
      if (i == 7)  chk("seq_c7_data", fe3.fe_data, W1);
      if (i == 11) chk("seq_c11_data", fe3.fe_data, WA);
    end
    nxt(); fe3.fe_req = 1'b0; settle();
    chk("seq_count", cnt3, 32'd3);

    // Redirect in WAIT: old address gets no ack, new one acked 3 cycles after redirect.
    nxt(); fe3.fe_req = 1'b1; fe3.fe_addr = Base;
    nxt();
    nxt(); fe3.fe_addr = Base + 32'h10; settle();
    chk("rdr_c2_ack", {31'b0, fe3.fe_ack}, 32'd0);
    nxt(); settle();
    chk("rdr_c3_ack", {31'b0, fe3.fe_ack}, 32'd0);
    nxt(); settle();
    chk("rdr_c4_ack", {31'b0, fe3.fe_ack}, 32'd0);
    nxt(); settle();
    chk("rdr_c5_ack", {31'b0, fe3.fe_ack}, 32'd1);
    chk("rdr_c5_data", fe3.fe_data, W4);
    nxt(); fe3.fe_req = 1'b0; settle();
    chk("rdr_count", cnt3, 32'd4);

    // Faults: misaligned, then first address past the end of the RAM.
    nxt(); fe1.fe_req = 1'b1; fe1.fe_addr = Base + 32'd2;
    nxt(); settle();
    chk("mis_ack", {31'b0, fe1.fe_ack}, 32'd1);
    chk("mis_data", fe1.fe_data, 32'd0);
    chk("mis_err", {31'b0, fe1.fe_err}, 32'd1);
    nxt(); fe1.fe_addr = Base + 32'h4000;
    nxt(); settle();
    chk("oor_ack", {31'b0, fe1.fe_ack}, 32'd1);
    chk("oor_data", fe1.fe_data, 32'd0);
    chk("oor_err", {31'b0, fe1.fe_err}, 32'd1);
    nxt(); fe1.fe_req = 1'b0; settle();
    chk("oor_hold_data", fe1.fe_data, 32'd0);
    chk("oor_hold_err", {31'b0, fe1.fe_err}, 32'd0);
    chk("flt_count", cnt1, 32'd3);

    // Same-edge loader write and fetch read of RAM[2]: old word first, new word next.
    nxt(); fe1.fe_req = 1'b1; fe1.fe_addr = Base + 32'd8;
    ld_wen = 1'b1; ld_addr = Base + 32'd8; ld_data = WB;
    nxt(); ld_wen = 1'b0; settle();
    chk("rbw_ack", {31'b0, fe1.fe_ack}, 32'd1);
    chk("rbw_old", fe1.fe_data, WA);
    nxt();
    nxt(); settle();
    chk("rbw_ack2", {31'b0, fe1.fe_ack}, 32'd1);
    chk("rbw_new", fe1.fe_data, WB);
    nxt(); fe1.fe_req = 1'b0; settle();
    chk("rbw_count", cnt1, 32'd5);

    // Reset while the LATENCY 4 instance is in WAIT.
    nxt(); fe4.fe_req = 1'b1; fe4.fe_addr = Base + 32'd4;
    nxt(); settle();
    chk("rw_c1_ack", {31'b0, fe4.fe_ack}, 32'd0);
    nxt(); reset_n = 1'b0; settle();
    chk("rw_c2_ack", {31'b0, fe4.fe_ack}, 32'd0);
    nxt(); reset_n = 1'b1; fe4.fe_req = 1'b0; settle();
    chk("rw_c3_ack", {31'b0, fe4.fe_ack}, 32'd0);
    chk("rw_c3_data", fe4.fe_data, Nop);
    chk("rw_c3_count", cnt4, 32'd0);
    chk("rw_c3_count_l1", cnt1, 32'd0);
    nxt(); fe4.fe_req = 1'b1; fe4.fe_addr = Base + 32'd4;
    repeat (3) nxt();
    settle();
    chk("rw_n3_ack", {31'b0, fe4.fe_ack}, 32'd0);
    nxt(); settle();
    chk("rw_n4_ack", {31'b0, fe4.fe_ack}, 32'd1);
    chk("rw_n4_data", fe4.fe_data, W1);
    nxt(); fe4.fe_req = 1'b0; settle();
    chk("rw_count", cnt4, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch stage's request/acknowledge port. Holds a word-addressed instruction RAM mapped at BASE_ADDR. Returns one word per accepted request after a programmable latency, and aborts cleanly when fetch redirects mid-transaction. A separate loader write port fills the RAM before or during execution, and a 32-bit counter tracks completed fetches.

## Interface
- DEPTH, 4096: RAM size in 32-bit words; power of two.
- LATENCY, 1: cycles from request acceptance to the ACK cycle; legal range 1..15.
- BASE_ADDR, 32'h80000000: byte address of word 0.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- fe_req  in  1  fetch request; held with fe_addr until acked or redirected.
- fe_addr  in  32  byte address of requested instruction.
- fe_ack  out  1  one-cycle acknowledge; fe_data valid this cycle.
- fe_data  out  32  instruction word; stable from an ack cycle until the next ack.
- fe_err  out  1  high with fe_ack when the address was out of range or misaligned.
- ld_wen  in  1  loader word write enable.
- ld_addr  in  32  loader byte address; same map as fe_addr.
- ld_data  in  32  loader write data.
- ack_count  out  32  number of fe_ack cycles since reset; wraps.

## Operation
- Address check: in range iff fe_addr[1:0]==0 and (fe_addr-BASE_ADDR)>>2 < DEPTH. Index = (fe_addr-BASE_ADDR)[log2(DEPTH)+1:2].
- Out-of-range or misaligned request: the block still completes after LATENCY. The ack returns fe_data=32'h00000000 with fe_err=1.
- Loader write: on an edge with ld_wen=1 and ld_addr in range, RAM[index] <= ld_data. Out-of-range loader writes are dropped.
- States: IDLE, WAIT, ACK. Registers: lat_addr[31:0], cnt[3:0], stage_data, stage_err, hold_data, hold_err.
- IDLE: if fe_req=1, then lat_addr <= fe_addr and cnt <= LATENCY-1. Go to ACK if LATENCY==1, else go to WAIT.
- WAIT: if fe_req=0, go to IDLE (abort). If fe_addr!=lat_addr, relatch fe_addr, reload cnt, and stay/branch as from IDLE (restart). Otherwise decrement cnt, and go to ACK when cnt==1.
- Read: on the edge entering ACK, stage_data <= RAM[index(lat_addr)] (or 0) and stage_err <= range fault. Reads see RAM contents before any same-edge loader write (read-before-write).
- ACK: fe_ack = (state==ACK) & fe_req & (fe_addr==lat_addr), combinational.
  - If fe_ack=1: hold_data <= stage_data, hold_err <= stage_err, ack_count++, go to IDLE.
  - If fe_ack=0 and fe_req=1: restart with the new address as from IDLE.
  - If fe_ack=0 and fe_req=0: go to IDLE.
- fe_data = (state==ACK) ? stage_data : hold_data. fe_err = fe_ack & stage_err. fe_data keeps its value after the ack so the downstream stage can consume it the following cycle.
- The ACK cycle never starts a new transaction. The next request is accepted in the IDLE cycle after the ack, when fetch presents the new address.

## Timing
- Reset values: state=IDLE, fe_ack=0, fe_err=0, hold_data=stage_data=32'h00000013 (NOP, bit 6 clear), fe_data=32'h00000013, ack_count=0. RAM contents are not reset.
- Request first high in cycle 0 with a stable address: fe_ack is high in cycle LATENCY.
- Throughput: one ack per LATENCY+1 cycles under back-to-back requests.
- Redirect during WAIT or ACK: the old transaction produces no ack. The new address is acked LATENCY cycles after the redirect cycle.
- Reset mid-transaction: on the reset edge the block returns to IDLE with no ack and fe_data=NOP.
- Loader write and fetch read of the same word in the read edge: the fetch returns the old word, and the next fetch returns the new word.
- ack_count wraps from 32'hFFFFFFFF to 0.

## Test plan
- LATENCY=1: load RAM[0]=32'h00100093, hold fe_req=1 with fe_addr=32'h80000000 from cycle 0 -> fe_ack=1 in cycle 1 with fe_data=32'h00100093, fe_err=0. fe_data still 32'h00100093 in cycle 2; ack_count=1.
- LATENCY=3: sequential requests to 0x80000000, 0x80000004, 0x80000008 with the address advanced after each ack -> acks in cycles 3, 7, 11; ack_count=3.
- Redirect: LATENCY=3, request 0x80000000 in cycle 0, fe_addr changed to 0x80000010 in cycle 2 -> no ack in cycle 3. Ack in cycle 5 with RAM[4] data.
- Fault: fe_addr=32'h80000002 and fe_addr=BASE_ADDR+4*DEPTH -> each acked with fe_data=0, fe_err=1.
- Same-edge conflict: LATENCY=1, RAM[2]=A, ld_wen writing B to 0x80000008 in cycle 0 while requesting 0x80000008 -> ack returns A. The following request to the same address returns B.
- Reset in WAIT: LATENCY=4, reset_n=0 in cycle 2 -> no ack, fe_data=32'h00000013, ack_count=0, and a new request is served normally afterward.
